// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter and sequencer for register-to-register moves on a shared data bus.
// Every move runs DRIVE -> LATCH -> TURN so the bus never sees two drivers in one cycle.
module bus_transfer_arbiter #(
   parameter int NUM_REGS = 16,
   parameter int AW       = 4,
   parameter int NUM_REQ  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0][AW-1:0] req_src,
   input  logic [NUM_REQ-1:0][AW-1:0] req_dst,
   output logic [NUM_REQ-1:0]         done,
   output logic                       err,
   output logic                       busy,
   output logic [NUM_REGS-1:0]        reg_out_en,
   output logic [NUM_REGS-1:0]        reg_in_en
);
   localparam int            PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PW:0]   NREQ  = (PW+1)'(NUM_REQ);
   localparam logic [PW-1:0] LAST  = PW'(NUM_REQ-1);
   localparam logic [AW:0]   NREGS = (AW+1)'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, DRIVE, LATCH, TURN} state_t;

   typedef struct packed {
      logic [PW-1:0] id;
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
   } move_t;

   state_t              state, state_nxt;
   logic [PW-1:0]       rr_ptr;
   move_t               mv, cand;
   logic                cand_bad, capture;
   logic [PW-1:0]       grant_id;
   logic                grant_vld;
   logic [PW:0]         slot;
   logic [NUM_REGS-1:0] out_nxt, in_nxt;
   logic [NUM_REQ-1:0]  done_nxt;
   logic                err_nxt;

   function automatic logic [NUM_REGS-1:0] dec(input logic [AW-1:0] idx);
      logic [NUM_REGS-1:0] v;
      v = '0;
      for (int r = 0; r < NUM_REGS; r++) v[r] = (idx == AW'(r));
      return v;
   endfunction

   // First requester at or after rr_ptr, scanning with modulo wrap.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      slot      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = {1'b0, rr_ptr} + (PW+1)'(k);
         if (slot >= NREQ) slot = slot - NREQ;
         if (!grant_vld && req[slot[PW-1:0]]) begin
            grant_vld = 1'b1;
            grant_id  = slot[PW-1:0];
         end
      end
   end

   assign cand     = {grant_id, req_src[grant_id], req_dst[grant_id]};
   assign cand_bad = ({1'b0, cand.src} >= NREGS) || ({1'b0, cand.dst} >= NREGS);

   // Outputs are computed for the state being entered and registered with it.
   always_comb begin
      state_nxt = state;
      out_nxt   = '0;
      in_nxt    = '0;
      done_nxt  = '0;
      err_nxt   = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               capture = 1'b1;
               if (cand_bad) begin
                  state_nxt          = TURN;
                  done_nxt[cand.id]  = 1'b1;
                  err_nxt            = 1'b1;
               end else begin
                  state_nxt = DRIVE;
                  out_nxt   = dec(cand.src);
               end
            end
         end
         DRIVE: begin
            state_nxt       = LATCH;
            out_nxt         = dec(mv.src);
            in_nxt          = dec(mv.dst);
            done_nxt[mv.id] = 1'b1;
         end
         LATCH:   state_nxt = TURN;
         TURN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         mv         <= '0;
         reg_out_en <= '0;
         reg_in_en  <= '0;
         done       <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         reg_out_en <= out_nxt;
         reg_in_en  <= in_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         busy       <= (state_nxt != IDLE);
         if (capture) begin
            mv     <= cand;
            rr_ptr <= (cand.id == LAST) ? '0 : cand.id + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Scoreboard bench for bus_transfer_arbiter with a behavioural register file on the bus.
module tb_bus_transfer_arbiter;
   localparam int NUM_REGS = 12;
   localparam int AW       = 4;
   localparam int NUM_REQ  = 4;
   localparam int IDW      = $clog2(NUM_REQ);
   localparam int SOAK     = 10000;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [AW-1:0]  src;
      logic [AW-1:0]  dst;
      logic           rej;
   } exp_t;

   logic                       clk, rst_n;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ-1:0][AW-1:0] req_src, req_dst;
   logic [NUM_REQ-1:0]         done;
   logic                       err, busy;
   logic [NUM_REGS-1:0]        reg_out_en, reg_in_en;

   bus_transfer_arbiter #(.NUM_REGS(NUM_REGS), .AW(AW), .NUM_REQ(NUM_REQ)) dut (
      .clk(clk), .rst(rst_n), .req(req), .req_src(req_src), .req_dst(req_dst),
      .done(done), .err(err), .busy(busy), .reg_out_en(reg_out_en), .reg_in_en(reg_in_en)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        tb_init;
   logic        hold_req;
   logic [15:0] regs  [NUM_REGS];
   logic [15:0] mregs [NUM_REGS];
   logic [15:0] bus;
   exp_t        exp_q[$];
   int          done_id[$];
   int          done_cyc[$];
   int          mon_id;
   bit          mon_found;
   exp_t        mon_e;
   logic [4:0]  inv;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input int r);
      return (r == 3) ? 16'hBEEF : 16'(r * 257 + 4608);
   endfunction

   function automatic logic [NUM_REGS-1:0] onehot(input int i);
      logic [NUM_REGS-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Tri-state bus and the registers hanging on it.
   always_comb begin
      bus = 16'hxxxx;
      for (int r = 0; r < NUM_REGS; r++) if (reg_out_en[r]) bus = regs[r];
   end

   always @(posedge clk) begin
      if (tb_init) for (int r = 0; r < NUM_REGS; r++) regs[r] <= init_val(r);
      else for (int r = 0; r < NUM_REGS; r++) if (reg_in_en[r]) regs[r] <= bus;
   end

   // Scoreboard pop on done, register model update, and per-cycle invariants.
   always @(negedge clk) begin
      if (tb_init) begin
         for (int r = 0; r < NUM_REGS; r++) mregs[r] = init_val(r);
      end else if (done != '0) begin
         mon_id    = 0;
         mon_found = 1'b0;
         mon_e     = '0;
         for (int i = 0; i < NUM_REQ; i++) if (done[i]) mon_id = i;
         for (int k = 0; k < exp_q.size(); k++) begin
            if (!mon_found && int'(exp_q[k].id) == mon_id) begin
               mon_e     = exp_q[k];
               mon_found = 1'b1;
               exp_q.delete(k);
            end
         end
         chk("sb_found", 32'(mon_found), 32'd1);
         if (mon_found) begin
            chk("sb_err", 32'(err), 32'(mon_e.rej));
            chk("sb_out", 32'(reg_out_en), mon_e.rej ? 32'd0 : 32'(onehot(int'(mon_e.src))));
            chk("sb_in", 32'(reg_in_en), mon_e.rej ? 32'd0 : 32'(onehot(int'(mon_e.dst))));
            if (!mon_e.rej) mregs[mon_e.dst] = mregs[mon_e.src];
         end
         done_id.push_back(mon_id);
         done_cyc.push_back(cyc);
      end
      inv = {($countones(reg_out_en) <= 1), ($countones(reg_in_en) <= 1),
             ($countones(done) <= 1), (reg_in_en == '0 || reg_out_en != '0),
             (!err || done != '0)};
      chk("invariant", 32'(inv), 32'h1F);
   end

   task automatic step();
      @(negedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (done[i] && !hold_req) req[i] = 1'b0;
   endtask

   task automatic push_exp(input int i, input int s, input int d);
      exp_t e;
      e.id  = IDW'(i);
      e.src = AW'(s);
      e.dst = AW'(d);
      e.rej = (s >= NUM_REGS) || (d >= NUM_REGS);
      exp_q.push_back(e);
   endtask

   task automatic issue(input int i, input int s, input int d);
      req_src[i] = AW'(s);
      req_dst[i] = AW'(d);
      req[i]     = 1'b1;
      push_exp(i, s, d);
   endtask

   task automatic drain(input int budget);
      int t;
      t = 0;
      while ((req != '0 || busy) && t < budget) begin
         step();
         t++;
      end
      chk("drain_timeout", 32'(req != '0 || busy), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t, s, d;
      rst_n    = 1'b0;
      tb_init  = 1'b1;
      hold_req = 1'b0;
      req      = '0;
      req_src  = '0;
      req_dst  = '0;
      repeat (3) step();
      chk("reset_outputs", 32'({reg_out_en, reg_in_en, done, err, busy}), 32'd0);
      tb_init = 1'b0;
      rst_n   = 1'b1;
      step();

      // Reset in the middle of LATCH abandons the move.
      issue(1, 5, 9);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_latch_in", 32'(reg_in_en), 32'(onehot(9)));
      rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({reg_out_en, reg_in_en, done, err, busy}), 32'd0);
      exp_q.delete();
      req = '0;
      step();
      step();
      chk("rst_dst_kept", 32'(regs[9]), 32'(init_val(9)));
      rst_n = 1'b1;
      step();

      // All four requesters held high: expect 0,1,2,3,0 at 4-cycle spacing.
      hold_req = 1'b1;
      done_id.delete();
      done_cyc.delete();
      for (int i = 0; i < NUM_REQ; i++) issue(i, i, i + 8);
      n = 0;
      t = 0;
      while (n < 5 && t < 60) begin
         step();
         t++;
         if (done != '0) begin
            n++;
            if (n < 5) for (int i = 0; i < NUM_REQ; i++) if (done[i]) push_exp(i, i, i + 8);
         end
      end
      req      = '0;
      hold_req = 1'b0;
      chk("fair_count", 32'(n), 32'd5);
      repeat (3) step();
      chk("fair_idle", 32'(busy), 32'd0);
      exp_q.delete();
      if (done_id.size() >= 5) begin
         for (int k = 0; k < 5; k++) chk("fair_order", 32'(done_id[k]), 32'(k % NUM_REQ));
         for (int k = 1; k < 5; k++) chk("fair_gap", 32'(done_cyc[k] - done_cyc[k-1]), 32'd4);
      end

      // Single move R3 -> R7 with exact phase timing.
      issue(0, 3, 7);
      step();
      chk("mv_drive_out", 32'(reg_out_en), 32'(onehot(3)));
      chk("mv_drive_in", 32'(reg_in_en), 32'd0);
      chk("mv_drive_done", 32'(done), 32'd0);
      chk("mv_drive_busy", 32'(busy), 32'd1);
      step();
      chk("mv_latch_out", 32'(reg_out_en), 32'(onehot(3)));
      chk("mv_latch_in", 32'(reg_in_en), 32'(onehot(7)));
      chk("mv_latch_done", 32'(done), 32'b0001);
      step();
      chk("mv_turn_en", 32'({reg_out_en, reg_in_en}), 32'd0);
      chk("mv_r7", 32'(regs[7]), 32'hBEEF);
      step();
      chk("mv_idle_busy", 32'(busy), 32'd0);

      // Out-of-range destination is rejected straight into TURN.
      issue(2, 1, 13);
      step();
      chk("rej_done", 32'(done), 32'b0100);
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_en", 32'({reg_out_en, reg_in_en}), 32'd0);
      chk("rej_busy", 32'(busy), 32'd1);
      issue(0, 2, 4);
      step();
      chk("rej_next_idle", 32'({reg_out_en, busy}), 32'd0);
      step();
      chk("rej_next_drive", 32'(reg_out_en), 32'(onehot(2)));
      step();
      chk("rej_next_done", 32'(done), 32'b0001);
      chk("rej_next_in", 32'(reg_in_en), 32'(onehot(4)));
      drain(20);

      // rr_ptr is 2 after serving requester 1; then 1 and 3 contend.
      issue(1, 4, 5);
      drain(20);
      done_id.delete();
      issue(1, 6, 7);
      issue(3, 8, 9);
      drain(40);
      chk("cont_count", 32'(done_id.size()), 32'd2);
      if (done_id.size() >= 2) begin
         chk("cont_first", 32'(done_id[0]), 32'd3);
         chk("cont_second", 32'(done_id[1]), 32'd1);
      end

      // Random soak, including occasional out-of-range indices.
      for (int c = 0; c < SOAK; c++) begin
         step();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] && !done[i] && $urandom_range(0, 3) == 0) begin
               s = int'($urandom_range(0, NUM_REGS - 1));
               d = int'($urandom_range(0, NUM_REGS - 1));
               if ($urandom_range(0, 15) == 0) d = int'($urandom_range(NUM_REGS, 15));
               if ($urandom_range(0, 31) == 0) s = int'($urandom_range(NUM_REGS, 15));
               issue(i, s, d);
            end
         end
      end
      drain(400);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      for (int r = 0; r < NUM_REGS; r++) chk("reg_final", 32'(regs[r]), 32'(mregs[r]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
